tm_engine: RTL and testbench

//  Programmable, parametrised Turing-machine runner for the busy-beaver display design. Transition table is loaded
//  at run time through a rule port, not hard-coded, so any QBITS-state / SBITS-symbol machine runs without resynthesis.

---
 rtl/tm_pkg.sv | 18 +
 rtl/tm_rule_ram.sv | 26 ++
 rtl/tm_engine.sv | 167 ++++++++++++++++
 tb/tb_tm_engine.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tm_pkg.sv
// Shared types and constants for the Turing-machine engine.
package tm_pkg;

    // Top-level engine phases.
    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_READ,
        S_WRITE,
        S_MOVE,
        S_DONE
    } fsm_e;

    // Head movement encoding in the rule word.
    localparam logic DIR_L = 1'b0;
    localparam logic DIR_R = 1'b1;

endpackage

// File: rtl/tm_rule_ram.sv
// Transition table: {state, symbol} -> {newsym, dir, next}; sync write, async read.
module tm_rule_ram #(
    parameter int SBITS = 3,
    parameter int QBITS = 2
) (
    input  logic                   clk,
    input  logic                   we,
    input  logic [QBITS+SBITS-1:0] waddr,
    input  logic [SBITS+QBITS:0]   wdata,
    input  logic [QBITS+SBITS-1:0] raddr,
    output logic [SBITS+QBITS:0]   rdata
);

    localparam int DEPTH = 2 ** (QBITS + SBITS);

    logic [SBITS+QBITS:0] mem [DEPTH];

    // Table write port.
    // NOTE: the table has no reset so it maps onto plain RAM and a loaded machine survives rst_n.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/tm_engine.sv
// Programmable Turing-machine runner with external tape memory handshake.
module tm_engine
    import tm_pkg::*;
#(
    parameter int ABITS        = 16,
    parameter int SBITS        = 3,
    parameter int QBITS        = 2,
    parameter int CBITS        = 32,
    parameter int SLEEP_CYCLES = 50_000_000
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic                   auto_restart,
    input  logic                   rule_we,
    input  logic [QBITS+SBITS-1:0] rule_addr,
    input  logic [SBITS+QBITS:0]   rule_data,
    output logic [ABITS-1:0]       m_addr,
    output logic                   m_ena,
    output logic                   m_write,
    output logic [SBITS-1:0]       wr_data,
    input  logic [SBITS-1:0]       rd_data,
    input  logic                   m_ack,
    input  logic                   m_busy,
    output logic [CBITS-1:0]       step_count,
    output logic [ABITS-1:0]       head_pos,
    output logic                   running,
    output logic                   done,
    output logic                   err_tape,
    output logic                   err_cnt
);

    typedef struct packed {
        logic [SBITS-1:0] newsym;
        logic             dir;
        logic [QBITS-1:0] next;
    } rule_t;

    localparam int                SLW        = $clog2(SLEEP_CYCLES + 1);
    localparam logic [SLW-1:0]    SLEEP_LAST = SLW'(SLEEP_CYCLES - 1);
    localparam logic [QBITS-1:0]  HALT       = '1;
    localparam logic [ABITS-1:0]  ADDR_MAX   = '1;
    localparam logic [ABITS-1:0]  HEAD_HOME  = {1'b1, {(ABITS-1){1'b0}}};
    localparam logic [CBITS-1:0]  CNT_MAX    = '1;

    fsm_e               fsm, fsm_next;
    logic [QBITS-1:0]   q;
    logic [SBITS-1:0]   sym;
    logic [ABITS-1:0]   head;
    logic [SLW-1:0]     sleep_cnt;
    logic               req_out;
    logic               issue;
    logic               acked;
    logic               at_edge;
    logic               idle_like;
    logic [SBITS+QBITS:0] rule_raw;
    rule_t              rule;

    tm_rule_ram #(.SBITS(SBITS), .QBITS(QBITS)) u_rules (
        .clk   (clk),
        .we    (rule_we && idle_like),
        .waddr (rule_addr),
        .wdata (rule_data),
        .raddr ({q, sym}),
        .rdata (rule_raw)
    );

    assign rule      = rule_t'(rule_raw);
    assign idle_like = (fsm == S_IDLE) || (fsm == S_DONE);
    // A request already on the bus is held; a new one waits for m_busy to clear.
    assign issue     = req_out || !m_busy;
    assign acked     = m_ena && m_ack;
    assign at_edge   = (rule.dir == DIR_L && head == '0) || (rule.dir == DIR_R && head == ADDR_MAX);

    assign m_addr   = head;
    assign head_pos = head;
    assign running  = (fsm == S_CLR) || (fsm == S_READ) || (fsm == S_WRITE) || (fsm == S_MOVE);
    assign done     = (fsm == S_DONE);

    // FSM state register.
    // NOTE: all clocked state uses non-blocking assignment so every register sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) fsm <= S_IDLE;
        else        fsm <= fsm_next;
    end

    // Next-state and memory request outputs.
    // NOTE: every output is given a default first so no path leaves one unassigned (no latches).
    always_comb begin
        fsm_next = fsm;
        m_ena    = 1'b0;
        m_write  = 1'b0;
        wr_data  = '0;
        case (fsm)
            S_IDLE:  if (start) fsm_next = S_CLR;
            S_CLR: begin
                m_ena   = issue;
                m_write = 1'b1;
                if (issue && m_ack && head == '0) fsm_next = S_READ;
            end
            S_READ: begin
                m_ena = issue;
                if (issue && m_ack) fsm_next = S_WRITE;
            end
            S_WRITE: begin
                m_ena   = issue;
                m_write = 1'b1;
                wr_data = rule.newsym;
                if (issue && m_ack) fsm_next = S_MOVE;
            end
            S_MOVE:  fsm_next = (step_count == CNT_MAX || at_edge || rule.next == HALT) ? S_DONE : S_READ;
            S_DONE:  if (start || (auto_restart && sleep_cnt == SLEEP_LAST)) fsm_next = S_CLR;
            default: fsm_next = S_IDLE;
        endcase
    end

    // Head, machine state, counters, error flags and request tracking.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            q          <= '0;
            sym        <= '0;
            head       <= '0;
            step_count <= '0;
            err_tape   <= 1'b0;
            err_cnt    <= 1'b0;
            sleep_cnt  <= '0;
            req_out    <= 1'b0;
        end else begin
            req_out   <= m_ena && !m_ack;
            sleep_cnt <= (fsm == S_DONE && auto_restart && fsm_next == S_DONE) ? sleep_cnt + 1'b1 : '0;
            case (fsm)
                S_IDLE, S_DONE: begin
                    if (fsm_next == S_CLR) head <= ADDR_MAX;
                end
                S_CLR: begin
                    if (acked) begin
                        if (head == '0) begin
                            head       <= HEAD_HOME;
                            q          <= '0;
                            step_count <= '0;
                            err_tape   <= 1'b0;
                            err_cnt    <= 1'b0;
                        end else begin
                            head <= head - 1'b1;
                        end
                    end
                end
                S_READ: begin
                    if (acked) sym <= rd_data;
                end
                S_MOVE: begin
                    if (step_count == CNT_MAX) begin
                        err_cnt <= 1'b1;
                    end else begin
                        step_count <= step_count + 1'b1;
                        q          <= rule.next;
                        if (at_edge)                 err_tape <= 1'b1;
                        else if (rule.dir == DIR_R)  head     <= head + 1'b1;
                        else                         head     <= head - 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_tm_engine.sv
// Directed bench for tm_engine: 16-cell tape, 4-bit step counter, 10-cycle sleep.
module tb_tm_engine;

    localparam int ABITS = 4;
    localparam int SBITS = 3;
    localparam int QBITS = 2;
    localparam int CBITS = 4;
    localparam int SLEEP = 10;
    localparam int CELLS = 2 ** ABITS;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   start = 1'b0;
    logic                   auto_restart = 1'b0;
    logic                   rule_we = 1'b0;
    logic [QBITS+SBITS-1:0] rule_addr = '0;
    logic [SBITS+QBITS:0]   rule_data = '0;
    logic [ABITS-1:0]       m_addr;
    logic                   m_ena;
    logic                   m_write;
    logic [SBITS-1:0]       wr_data;
    logic [SBITS-1:0]       rd_data;
    logic                   m_ack;
    logic                   m_busy;
    logic [CBITS-1:0]       step_count;
    logic [ABITS-1:0]       head_pos;
    logic                   running;
    logic                   done;
    logic                   err_tape;
    logic                   err_cnt;

    int checks = 0;
    int failures = 0;

    tm_engine #(
        .ABITS(ABITS), .SBITS(SBITS), .QBITS(QBITS), .CBITS(CBITS), .SLEEP_CYCLES(SLEEP)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .auto_restart(auto_restart),
        .rule_we(rule_we), .rule_addr(rule_addr), .rule_data(rule_data),
        .m_addr(m_addr), .m_ena(m_ena), .m_write(m_write), .wr_data(wr_data),
        .rd_data(rd_data), .m_ack(m_ack), .m_busy(m_busy),
        .step_count(step_count), .head_pos(head_pos), .running(running),
        .done(done), .err_tape(err_tape), .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    // Tape memory model: ack after a random 0..max_delay wait, then busy for busy_len cycles.
    logic [SBITS-1:0] tape [CELLS];
    int max_delay = 0;
    int busy_len  = 0;
    int wait_cnt  = 0;
    int target    = 0;
    int busy_cnt  = 0;

    assign m_busy  = (busy_cnt != 0);
    assign m_ack   = m_ena && (wait_cnt >= target);
    assign rd_data = tape[m_addr];

    always @(posedge clk) begin
        if (m_ena && m_ack) begin
            if (m_write) tape[m_addr] <= wr_data;
            wait_cnt <= 0;
            target   <= int'($urandom_range(max_delay, 0));
            busy_cnt <= busy_len;
        end else begin
            wait_cnt <= m_ena ? wait_cnt + 1 : 0;
            if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
        end
    end

    // Protocol monitor: a new request must never start while the memory is busy.
    logic ena_prev = 1'b0;
    int   ena_viol = 0;
    always @(negedge clk) begin
        if (m_ena && !ena_prev && m_busy) ena_viol++;
        ena_prev = m_ena;
    end

    function automatic int count_ones();
        int n = 0;
        for (int i = 0; i < CELLS; i++) if (tape[i] !== 3'd0) n++;
        return n;
    endfunction

    task automatic write_rule(input logic [1:0] q, input logic [2:0] s,
                              input logic [2:0] ns, input logic d, input logic [1:0] nx);
        @(negedge clk);
        rule_we   = 1'b1;
        rule_addr = {q, s};
        rule_data = {ns, d, nx};
        @(negedge clk);
        rule_we   = 1'b0;
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int n = 0;
        while (!done && n < 3000) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (done !== 1'b1) begin
            failures++;
            $display("FAIL %s_timeout done=%b after %0d cycles, required 1", tag, done, n);
        end
    endtask

    // 2-state busy beaver: A0 1RB, A1 1LB, B0 1LA, B1 1RH (A=0, B=1, H=3).
    task automatic load_bb2();
        write_rule(2'd0, 3'd0, 3'd1, 1'b1, 2'd1);
        write_rule(2'd0, 3'd1, 3'd1, 1'b0, 2'd1);
        write_rule(2'd1, 3'd0, 3'd1, 1'b0, 2'd0);
        write_rule(2'd1, 3'd1, 3'd1, 1'b1, 2'd3);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if ({m_ena, m_write, running, done, err_tape, err_cnt} !== 6'b0) begin
            failures++;
            $display("FAIL reset_flags got=%b exp=000000", {m_ena, m_write, running, done, err_tape, err_cnt});
        end
        checks++;
        if (step_count !== 4'd0) begin
            failures++;
            $display("FAIL reset_steps got=%0d exp=0", step_count);
        end
        checks++;
        if (head_pos !== 4'd0) begin
            failures++;
            $display("FAIL reset_head got=%0d exp=0", head_pos);
        end
    endtask

    task automatic test_bb2();
        load_bb2();
        pulse_start();
        // Attempted rule overwrite during the run must be ignored (A0 -> 0LH would stop after 1 step).
        write_rule(2'd0, 3'd0, 3'd0, 1'b0, 2'd3);
        wait_done("bb2");
        checks++;
        if (step_count !== 4'd6) begin
            failures++;
            $display("FAIL bb2_steps got=%0d exp=6", step_count);
        end
        checks++;
        if (count_ones() != 4) begin
            failures++;
            $display("FAIL bb2_ones got=%0d exp=4", count_ones());
        end
        checks++;
        if ({err_tape, err_cnt, running} !== 3'b000) begin
            failures++;
            $display("FAIL bb2_flags got=%b exp=000", {err_tape, err_cnt, running});
        end
        checks++;
        if (head_pos !== 4'd8) begin
            failures++;
            $display("FAIL bb2_head got=%0d exp=8", head_pos);
        end
    endtask

    task automatic test_one_step();
        int n = 0;
        int cycles = 0;
        write_rule(2'd0, 3'd0, 3'd1, 1'b1, 2'd3);
        pulse_start();
        while (!(m_ena && m_write && m_ack && running && head_pos == 4'd0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!done && cycles < 20);
        checks++;
        if (cycles != 3) begin
            failures++;
            $display("FAIL one_step_latency got=%0d exp=3", cycles);
        end
        @(negedge clk);
        checks++;
        if (step_count !== 4'd1) begin
            failures++;
            $display("FAIL one_step_steps got=%0d exp=1", step_count);
        end
        checks++;
        if (tape[8] !== 3'd1 || count_ones() != 1) begin
            failures++;
            $display("FAIL one_step_tape got tape8=%0d ones=%0d exp tape8=1 ones=1", tape[8], count_ones());
        end
        checks++;
        if (head_pos !== 4'd9) begin
            failures++;
            $display("FAIL one_step_head got=%0d exp=9", head_pos);
        end
    endtask

    task automatic test_tape_edge();
        // Rule write and start in the same DONE cycle: A0 -> 1LA must be used by the run.
        @(negedge clk);
        rule_we   = 1'b1;
        start     = 1'b1;
        rule_addr = {2'd0, 3'd0};
        rule_data = {3'd1, 1'b0, 2'd0};
        @(negedge clk);
        rule_we   = 1'b0;
        start     = 1'b0;
        wait_done("edge");
        checks++;
        if (step_count !== 4'd9) begin
            failures++;
            $display("FAIL edge_steps got=%0d exp=9", step_count);
        end
        checks++;
        if (head_pos !== 4'd0) begin
            failures++;
            $display("FAIL edge_head got=%0d exp=0", head_pos);
        end
        checks++;
        if ({err_tape, err_cnt} !== 2'b10) begin
            failures++;
            $display("FAIL edge_errs got=%b exp=10", {err_tape, err_cnt});
        end
        checks++;
        if (count_ones() != 9) begin
            failures++;
            $display("FAIL edge_ones got=%0d exp=9", count_ones());
        end
    endtask

    task automatic test_busy();
        max_delay = 5;
        busy_len  = 3;
        ena_viol  = 0;
        load_bb2();
        pulse_start();
        wait_done("busy");
        checks++;
        if (step_count !== 4'd6) begin
            failures++;
            $display("FAIL busy_steps got=%0d exp=6", step_count);
        end
        checks++;
        if (count_ones() != 4) begin
            failures++;
            $display("FAIL busy_ones got=%0d exp=4", count_ones());
        end
        checks++;
        if ({err_tape, err_cnt} !== 2'b00) begin
            failures++;
            $display("FAIL busy_errs got=%b exp=00", {err_tape, err_cnt});
        end
        checks++;
        if (ena_viol != 0) begin
            failures++;
            $display("FAIL busy_protocol got=%0d requests raised while busy, exp=0", ena_viol);
        end
        max_delay = 0;
        busy_len  = 0;
    endtask

    task automatic test_reset_mid();
        pulse_start();
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if ({m_ena, m_write, m_addr, wr_data, step_count, head_pos, running, done, err_tape, err_cnt} !== '0) begin
            failures++;
            $display("FAIL mid_reset got ena=%b wr=%b addr=%0d wd=%0d steps=%0d head=%0d run=%b done=%b et=%b ec=%b exp all 0",
                     m_ena, m_write, m_addr, wr_data, step_count, head_pos, running, done, err_tape, err_cnt);
        end
        @(negedge clk);
        rst_n = 1'b1;
        pulse_start();
        wait_done("rerun");
        checks++;
        if (step_count !== 4'd6) begin
            failures++;
            $display("FAIL rerun_steps got=%0d exp=6", step_count);
        end
        checks++;
        if (count_ones() != 4) begin
            failures++;
            $display("FAIL rerun_ones got=%0d exp=4", count_ones());
        end
    endtask

    task automatic test_overflow_sleep();
        int cycles = 0;
        // Ping-pong between cells 8 and 9 forever: A0 -> 0RB, B0 -> 0LA.
        write_rule(2'd0, 3'd0, 3'd0, 1'b1, 2'd1);
        write_rule(2'd1, 3'd0, 3'd0, 1'b0, 2'd0);
        auto_restart = 1'b1;
        pulse_start();
        wait_done("ovf");
        checks++;
        if (step_count !== 4'd15) begin
            failures++;
            $display("FAIL ovf_steps got=%0d exp=15", step_count);
        end
        checks++;
        if ({err_tape, err_cnt} !== 2'b01) begin
            failures++;
            $display("FAIL ovf_errs got=%b exp=01", {err_tape, err_cnt});
        end
        checks++;
        if (head_pos !== 4'd9) begin
            failures++;
            $display("FAIL ovf_head got=%0d exp=9", head_pos);
        end
        do begin
            @(posedge clk);
            #1;
            cycles++;
        end while (!running && cycles < 50);
        checks++;
        if (cycles != SLEEP) begin
            failures++;
            $display("FAIL sleep_restart got=%0d exp=%0d", cycles, SLEEP);
        end
        auto_restart = 1'b0;
        wait_done("ovf_rerun");
        checks++;
        if (step_count !== 4'd15 || err_cnt !== 1'b1) begin
            failures++;
            $display("FAIL ovf_rerun got steps=%0d err_cnt=%b exp steps=15 err_cnt=1", step_count, err_cnt);
        end
    endtask

    initial begin
        test_reset();
        test_bb2();
        test_one_step();
        test_tape_edge();
        test_busy();
        test_reset_mid();
        test_overflow_sleep();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
